// File: rtl/ccip_mmio_csr_responder_if.sv
// CCI-P MMIO request (Rx c0) and read-response (Tx c2) signals between host side and AFU.
interface ccip_mmio_csr_responder_if;
    logic        c0_mmio_rd_valid;
    logic        c0_mmio_wr_valid;
    logic [15:0] c0_address;
    logic [1:0]  c0_length;
    logic [8:0]  c0_tid;
    logic [63:0] c0_data;

    logic        c2_mmio_rd_valid;
    logic [8:0]  c2_tid;
    logic [63:0] c2_data;

    modport master (
        output c0_mmio_rd_valid, c0_mmio_wr_valid, c0_address, c0_length, c0_tid, c0_data,
        input  c2_mmio_rd_valid, c2_tid, c2_data
    );

    modport slave (
        input  c0_mmio_rd_valid, c0_mmio_wr_valid, c0_address, c0_length, c0_tid, c0_data,
        output c2_mmio_rd_valid, c2_tid, c2_data
    );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// AFU MMIO CSR block: DFH, AFU_ID, scratch and write counter, answering reads on c2
// with a fixed two-cycle pipeline.
module ccip_mmio_csr_responder #(
    parameter logic [63:0] AFU_ID_L        = 64'h0,
    parameter logic [63:0] AFU_ID_H        = 64'h0,
    parameter logic [3:0]  FEATURE_REV     = 4'h0,
    parameter logic [23:0] NEXT_DFH_OFFSET = 24'h0,
    parameter logic        DFH_EOL         = 1'b1,
    parameter logic [63:0] SCRATCH_RESET   = 64'h0
) (
    input  logic                            pClk,
    input  logic                            pck_cp2af_softReset,
    ccip_mmio_csr_responder_if.slave        ccip,
    output logic [63:0]                     scratch_q
);

    typedef enum logic [1:0] {
        LEN_4B  = 2'd0,
        LEN_8B  = 2'd1,
        LEN_64B = 2'd2
    } mmio_len_e;

    localparam logic [63:0] DFH = {4'h1, 19'h0, DFH_EOL, NEXT_DFH_OFFSET, FEATURE_REV, 12'h0};

    localparam logic [14:0] IDX_DFH      = 15'd0;
    localparam logic [14:0] IDX_AFU_ID_L = 15'd1;
    localparam logic [14:0] IDX_AFU_ID_H = 15'd2;
    localparam logic [14:0] IDX_SCRATCH  = 15'd5;
    localparam logic [14:0] IDX_WR_CNT   = 15'd6;

    logic [14:0] req_index;
    mmio_len_e   req_len;
    logic [63:0] wr_cnt;

    logic        s1_valid;
    logic [8:0]  s1_tid;
    logic [14:0] s1_index;
    logic        s1_upper;
    mmio_len_e   s1_len;

    logic [63:0] reg_val;
    logic [63:0] rd_data;

    assign req_index = ccip.c0_address[15:1];
    assign req_len   = mmio_len_e'(ccip.c0_length);

    // Write path: counter counts every accepted write, only index 5 stores data.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            scratch_q <= SCRATCH_RESET;
            wr_cnt    <= '0;
        end else if (ccip.c0_mmio_wr_valid) begin
            wr_cnt <= wr_cnt + 64'd1;
            if (req_index == IDX_SCRATCH) begin
                case (req_len)
                    LEN_8B: scratch_q <= ccip.c0_data;
                    LEN_4B: begin
                        if (ccip.c0_address[0])
                            scratch_q[63:32] <= ccip.c0_data[31:0];
                        else
                            scratch_q[31:0]  <= ccip.c0_data[31:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage 1: capture the read request.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            s1_valid <= 1'b0;
            s1_tid   <= '0;
            s1_index <= '0;
            s1_upper <= 1'b0;
            s1_len   <= LEN_4B;
        end else begin
            s1_valid <= ccip.c0_mmio_rd_valid;
            s1_tid   <= ccip.c0_tid;
            s1_index <= req_index;
            s1_upper <= ccip.c0_address[0];
            s1_len   <= req_len;
        end
    end

    always_comb begin
        reg_val = '0;
        case (s1_index)
            IDX_DFH:      reg_val = DFH;
            IDX_AFU_ID_L: reg_val = AFU_ID_L;
            IDX_AFU_ID_H: reg_val = AFU_ID_H;
            IDX_SCRATCH:  reg_val = scratch_q;
            IDX_WR_CNT:   reg_val = wr_cnt;
            default:      reg_val = '0;
        endcase
    end

    // 64B (and undefined) lengths still get a response, carrying zero data.
    always_comb begin
        rd_data = '0;
        case (s1_len)
            LEN_8B:  rd_data = reg_val;
            LEN_4B:  rd_data = {32'h0, s1_upper ? reg_val[63:32] : reg_val[31:0]};
            default: rd_data = '0;
        endcase
    end

    // Stage 2: drive the response; hdr/data hold when no response is issued.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            ccip.c2_mmio_rd_valid <= 1'b0;
            ccip.c2_tid           <= '0;
            ccip.c2_data          <= '0;
        end else begin
            ccip.c2_mmio_rd_valid <= s1_valid;
            if (s1_valid) begin
                ccip.c2_tid  <= s1_tid;
                ccip.c2_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed bench for ccip_mmio_csr_responder: register map, write counter, ordering and reset drop.
module tb_ccip_mmio_csr_responder;

    localparam logic [63:0] P_AFU_ID_L      = 64'h9D73_E8F2_A3C1_5B04;
    localparam logic [63:0] P_AFU_ID_H      = 64'hC000_C966_0D82_4272;
    localparam logic [63:0] P_SCRATCH_RESET = 64'h5A5A_0000_0000_A5A5;
    localparam logic [63:0] EXP_DFH         = 64'h1000_0100_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] scratch_q;
    int          checks = 0;
    int          passes = 0;

    ccip_mmio_csr_responder_if bus();

    ccip_mmio_csr_responder #(
        .AFU_ID_L      (P_AFU_ID_L),
        .AFU_ID_H      (P_AFU_ID_H),
        .SCRATCH_RESET (P_SCRATCH_RESET)
    ) dut (
        .pClk                (clk),
        .pck_cp2af_softReset (rst),
        .ccip                (bus),
        .scratch_q           (scratch_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.c0_mmio_rd_valid = 1'b0;
        bus.c0_mmio_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mmio_wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        bus.c0_mmio_wr_valid = 1'b1;
        bus.c0_address       = addr;
        bus.c0_length        = len;
        bus.c0_data          = data;
        @(negedge clk);
        idle();
    endtask

    task automatic mmio_rd(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid,
                           output logic v1, output logic v2, output logic v3,
                           output logic [8:0] t, output logic [63:0] d);
        bus.c0_mmio_rd_valid = 1'b1;
        bus.c0_address       = addr;
        bus.c0_length        = len;
        bus.c0_tid           = tid;
        @(negedge clk);
        idle();
        v1 = bus.c2_mmio_rd_valid;
        @(negedge clk);
        v2 = bus.c2_mmio_rd_valid;
        t  = bus.c2_tid;
        d  = bus.c2_data;
        @(negedge clk);
        v3 = bus.c2_mmio_rd_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.c0_address = '0; bus.c0_length = '0; bus.c0_tid = '0; bus.c0_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.c2_mmio_rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.c2_mmio_rd_valid); else passes++;
        checks++; if (bus.c2_tid !== 9'h0) $display("FAIL reset_tid: got %h want 000", bus.c2_tid); else passes++;
        checks++; if (bus.c2_data !== 64'h0) $display("FAIL reset_data: got %h want 0", bus.c2_data); else passes++;
        checks++; if (scratch_q !== P_SCRATCH_RESET) $display("FAIL reset_scratch: got %h want %h", scratch_q, P_SCRATCH_RESET); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dfh();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        mmio_rd(16'h0000, 2'd1, 9'h1A5, v1, v2, v3, t, d);
        checks++; if (v1 !== 1'b0) $display("FAIL dfh_early: got %b want 0", v1); else passes++;
        checks++; if (v2 !== 1'b1) $display("FAIL dfh_valid: got %b want 1", v2); else passes++;
        checks++; if (t !== 9'h1A5) $display("FAIL dfh_tid: got %h want 1a5", t); else passes++;
        checks++; if (d !== EXP_DFH) $display("FAIL dfh_data: got %h want %h", d, EXP_DFH); else passes++;
        checks++; if (v3 !== 1'b0) $display("FAIL dfh_single: got %b want 0", v3); else passes++;
    endtask

    task automatic test_afu_id();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        mmio_rd(16'h0002, 2'd1, 9'h021, v1, v2, v3, t, d);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || v3 !== 1'b0) $display("FAIL idl_latency: got %b%b%b want 010", v1, v2, v3); else passes++;
        checks++; if (d !== P_AFU_ID_L) $display("FAIL idl_data: got %h want %h", d, P_AFU_ID_L); else passes++;
        checks++; if (t !== 9'h021) $display("FAIL idl_tid: got %h want 021", t); else passes++;
        mmio_rd(16'h0004, 2'd1, 9'h0F0, v1, v2, v3, t, d);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || v3 !== 1'b0) $display("FAIL idh_latency: got %b%b%b want 010", v1, v2, v3); else passes++;
        checks++; if (d !== P_AFU_ID_H) $display("FAIL idh_data: got %h want %h", d, P_AFU_ID_H); else passes++;
        mmio_rd(16'h0006, 2'd1, 9'h001, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0) $display("FAIL rsvd_data: got %h want 0", d); else passes++;
    endtask

    task automatic test_scratch();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        mmio_wr(16'h000A, 2'd1, 64'hDEAD_BEEF_CAFE_F00D);
        checks++; if (scratch_q !== 64'hDEAD_BEEF_CAFE_F00D) $display("FAIL scr_wr8: got %h want deadbeefcafef00d", scratch_q); else passes++;
        mmio_wr(16'h000B, 2'd0, 64'hFFFF_0000_1234_5678);
        mmio_rd(16'h000A, 2'd1, 9'h005, v1, v2, v3, t, d);
        checks++; if (d !== 64'h1234_5678_CAFE_F00D) $display("FAIL scr_wr4hi: got %h want 12345678cafef00d", d); else passes++;
        mmio_rd(16'h000A, 2'd0, 9'h006, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0000_0000_CAFE_F00D) $display("FAIL scr_rd4lo: got %h want cafef00d", d); else passes++;
        mmio_rd(16'h000B, 2'd0, 9'h007, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0000_0000_1234_5678) $display("FAIL scr_rd4hi: got %h want 12345678", d); else passes++;
        mmio_rd(16'h000A, 2'd2, 9'h0AA, v1, v2, v3, t, d);
        checks++; if (v2 !== 1'b1 || v3 !== 1'b0 || t !== 9'h0AA) $display("FAIL rd64_resp: got v=%b%b tid=%h want 10 0aa", v2, v3, t); else passes++;
        checks++; if (d !== 64'h0) $display("FAIL rd64_data: got %h want 0", d); else passes++;
        mmio_wr(16'h000A, 2'd0, 64'h7777_7777_89AB_CDEF);
        checks++; if (scratch_q !== 64'h1234_5678_89AB_CDEF) $display("FAIL scr_wr4lo: got %h want 1234567889abcdef", scratch_q); else passes++;
    endtask

    task automatic test_wr_cnt();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) mmio_wr(16'h0040, 2'd1, 64'h1111_2222_3333_4444);
        mmio_wr(16'h000A, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        mmio_rd(16'h000C, 2'd1, 9'h030, v1, v2, v3, t, d);
        checks++; if (d !== 64'd4) $display("FAIL wrcnt_four: got %h want 4", d); else passes++;
        mmio_rd(16'h000C, 2'd0, 9'h031, v1, v2, v3, t, d);
        checks++; if (d !== 64'd4) $display("FAIL wrcnt_lo32: got %h want 4", d); else passes++;
        mmio_rd(16'h000A, 2'd1, 9'h032, v1, v2, v3, t, d);
        checks++; if (d !== P_SCRATCH_RESET) $display("FAIL wrcnt_scr_kept: got %h want %h", d, P_SCRATCH_RESET); else passes++;
        dut.wr_cnt <= 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        mmio_wr(16'h0100, 2'd0, 64'h0);
        mmio_rd(16'h000C, 2'd1, 9'h033, v1, v2, v3, t, d);
        checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrcnt_max: got %h want ffffffffffffffff", d); else passes++;
        mmio_wr(16'h0100, 2'd0, 64'h0);
        mmio_rd(16'h000C, 2'd1, 9'h034, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0) $display("FAIL wrcnt_wrap: got %h want 0", d); else passes++;
    endtask

    task automatic test_order();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        // write at N, read at N+1 sees the new value
        bus.c0_mmio_wr_valid = 1'b1; bus.c0_address = 16'h000A; bus.c0_length = 2'd1;
        bus.c0_data = 64'h0101_0101_0101_0101;
        @(negedge clk);
        bus.c0_mmio_wr_valid = 1'b0; bus.c0_mmio_rd_valid = 1'b1; bus.c0_tid = 9'h010;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (bus.c2_mmio_rd_valid !== 1'b1 || bus.c2_data !== 64'h0101_0101_0101_0101)
            $display("FAIL raw_new: got v=%b d=%h want 1 0101010101010101", bus.c2_mmio_rd_valid, bus.c2_data); else passes++;
        // read at N, write at N+1 sees the old value
        bus.c0_mmio_rd_valid = 1'b1; bus.c0_address = 16'h000A; bus.c0_length = 2'd1; bus.c0_tid = 9'h011;
        @(negedge clk);
        bus.c0_mmio_rd_valid = 1'b0; bus.c0_mmio_wr_valid = 1'b1; bus.c0_data = 64'h0202_0202_0202_0202;
        @(negedge clk);
        idle();
        checks++; if (bus.c2_mmio_rd_valid !== 1'b1 || bus.c2_tid !== 9'h011 || bus.c2_data !== 64'h0101_0101_0101_0101)
            $display("FAIL war_old: got v=%b t=%h d=%h want 1 011 0101010101010101", bus.c2_mmio_rd_valid, bus.c2_tid, bus.c2_data); else passes++;
        @(negedge clk);
        checks++; if (scratch_q !== 64'h0202_0202_0202_0202) $display("FAIL war_write: got %h want 0202020202020202", scratch_q); else passes++;
        // both valids in one cycle: write lands and read is still answered
        bus.c0_mmio_rd_valid = 1'b1; bus.c0_mmio_wr_valid = 1'b1; bus.c0_tid = 9'h012;
        bus.c0_data = 64'h0303_0303_0303_0303;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (bus.c2_mmio_rd_valid !== 1'b1 || bus.c2_tid !== 9'h012)
            $display("FAIL both_resp: got v=%b t=%h want 1 012", bus.c2_mmio_rd_valid, bus.c2_tid); else passes++;
        mmio_rd(16'h000A, 2'd1, 9'h013, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0303_0303_0303_0303) $display("FAIL both_write: got %h want 0303030303030303", d); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3];
        logic [8:0]  tids [3];
        logic [63:0] exp_d [3];
        logic        v [6];
        logic [8:0]  t [6];
        logic [63:0] d [6];
        addrs = '{16'h000A, 16'h000C, 16'h000E};
        tids  = '{9'd1, 9'd2, 9'd3};
        // scratch from test_order; wr_cnt = 3 writes after the wrap
        exp_d = '{64'h0303_0303_0303_0303, 64'd3, 64'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                bus.c0_mmio_rd_valid = 1'b1; bus.c0_address = addrs[i];
                bus.c0_length = 2'd1; bus.c0_tid = tids[i];
            end else begin
                idle();
            end
            @(negedge clk);
            v[i] = bus.c2_mmio_rd_valid; t[i] = bus.c2_tid; d[i] = bus.c2_data;
        end
        checks++; if (v[0] !== 1'b0) $display("FAIL b2b_early: got %b want 0", v[0]); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (v[i+1] !== 1'b1 || t[i+1] !== tids[i])
                $display("FAIL b2b_tid%0d: got v=%b t=%h want 1 %h", i, v[i+1], t[i+1], tids[i]); else passes++;
            checks++; if (d[i+1] !== exp_d[i])
                $display("FAIL b2b_data%0d: got %h want %h", i, d[i+1], exp_d[i]); else passes++;
        end
        checks++; if (v[4] !== 1'b0 || v[5] !== 1'b0) $display("FAIL b2b_tail: got %b%b want 00", v[4], v[5]); else passes++;
    endtask

    task automatic test_reset_drop();
        logic v1, v2, v3; logic [8:0] t; logic [63:0] d;
        bus.c0_mmio_rd_valid = 1'b1; bus.c0_address = 16'h000A; bus.c0_length = 2'd1; bus.c0_tid = 9'h055;
        @(negedge clk);
        rst = 1'b1;
        bus.c0_mmio_rd_valid = 1'b1; bus.c0_mmio_wr_valid = 1'b1; bus.c0_tid = 9'h056;
        bus.c0_data = 64'hABAB_ABAB_ABAB_ABAB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.c2_mmio_rd_valid !== 1'b0) $display("FAIL drop_in_rst%0d: got %b want 0", i, bus.c2_mmio_rd_valid); else passes++;
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.c2_mmio_rd_valid !== 1'b0) $display("FAIL drop_after%0d: got %b want 0", i, bus.c2_mmio_rd_valid); else passes++;
        end
        mmio_rd(16'h000A, 2'd1, 9'h057, v1, v2, v3, t, d);
        checks++; if (d !== P_SCRATCH_RESET) $display("FAIL drop_scratch: got %h want %h", d, P_SCRATCH_RESET); else passes++;
        mmio_rd(16'h000C, 2'd1, 9'h058, v1, v2, v3, t, d);
        checks++; if (d !== 64'h0) $display("FAIL drop_wrcnt: got %h want 0", d); else passes++;
    endtask

    initial begin
        test_reset();
        test_dfh();
        test_afu_id();
        test_scratch();
        test_wr_cnt();
        test_order();
        test_back_to_back();
        test_reset_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
